// File: rtl/pe_param_pkg.sv
// Shared definitions for the bit-column processing element: group-mode
// encodings, FSM state type and the lane term width helper.
package pe_param_pkg;

  localparam logic [1:0] MODE_G1 = 2'd0;
  localparam logic [1:0] MODE_G2 = 2'd1;
  localparam logic [1:0] MODE_G4 = 2'd2;
  localparam logic [1:0] MODE_G8 = 2'd3;

  typedef enum logic {
    ST_ACC    = 1'b0,
    ST_REDUCE = 1'b1
  } state_t;

  // Widest unsigned lane term: full activation sum shifted by the largest shift.
  function automatic int term_w(input int act_w, input int act_per, input int shift_w);
    return act_w + $clog2(act_per) + (1 << shift_w);
  endfunction

endpackage

// File: rtl/pe_param_bce.sv
// One bit-column lane: gate activations by the weight column, sum them,
// shift left and optionally negate, producing a sign-extended ACC_W term.
module bce_lane
  import pe_param_pkg::*;
#(
  parameter int ACT_PER_BCE = 8,
  parameter int ACT_W       = 8,
  parameter int SHIFT_W     = 3,
  parameter int ACC_W       = 24
) (
  input  logic [ACT_PER_BCE*ACT_W-1:0] act,
  input  logic [ACT_PER_BCE-1:0]       wcol,
  input  logic                         sign,
  input  logic [SHIFT_W-1:0]           shift,
  output logic [ACC_W-1:0]             term
);

  localparam int TERM_W = term_w(ACT_W, ACT_PER_BCE, SHIFT_W);

  logic [TERM_W-1:0] sum;
  logic [TERM_W-1:0] shifted;
  logic [ACC_W-1:0]  mag;

  // The unsigned magnitude is zero-extended, so negation yields the signed term.
  always_comb begin
    sum = '0;
    for (int i = 0; i < ACT_PER_BCE; i++) begin
      if (wcol[i]) sum = sum + TERM_W'(act[i*ACT_W +: ACT_W]);
    end
    shifted = sum << shift;
    mag     = ACC_W'(shifted);
    term    = sign ? -mag : mag;
  end

endmodule

// File: rtl/pe_param.sv
// Bit-column PE: per-lane accumulation across beats, group reduction at pass
// end, and a one-deep valid/ready output buffer.
module pe_param
  import pe_param_pkg::*;
#(
  parameter int NUM_BCE     = 4,
  parameter int ACT_PER_BCE = 8,
  parameter int ACT_W       = 8,
  parameter int SHIFT_W     = 3,
  parameter int ACC_W       = 24,
  parameter int CNT_W       = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_BCE*ACT_PER_BCE*ACT_W-1:0] in_act,
  input  logic [NUM_BCE*ACT_PER_BCE-1:0]       in_wcol,
  input  logic                                 in_sign,
  input  logic [NUM_BCE*SHIFT_W-1:0]           in_shift,
  input  logic                                 in_last,
  input  logic [1:0]                           in_mode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 clear,
  output logic [NUM_BCE*ACC_W-1:0]             out_data,
  output logic [CNT_W-1:0]                     out_count,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic                                 dbg_state
);

  localparam logic [2:0] MAX_M = 3'($clog2(NUM_BCE));

  if (ACC_W < term_w(ACT_W, ACT_PER_BCE, SHIFT_W) + 1) begin : g_acc_too_narrow
    $error("pe_param: ACC_W too narrow for the lane term width");
  end

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready.
  state_t           state;
  logic [ACC_W-1:0] acc  [NUM_BCE];
  logic [ACC_W-1:0] term [NUM_BCE];
  logic [ACC_W-1:0] grp  [NUM_BCE];
  logic [CNT_W-1:0] cnt;
  logic [1:0]       mode_q;
  logic [1:0]       eff_m;
  logic             accept;
  logic             buf_free;

  for (genvar l = 0; l < NUM_BCE; l++) begin : g_lane
    bce_lane #(
      .ACT_PER_BCE(ACT_PER_BCE),
      .ACT_W      (ACT_W),
      .SHIFT_W    (SHIFT_W),
      .ACC_W      (ACC_W)
    ) u_lane (
      .act  (in_act[l*ACT_PER_BCE*ACT_W +: ACT_PER_BCE*ACT_W]),
      .wcol (in_wcol[l*ACT_PER_BCE +: ACT_PER_BCE]),
      .sign (in_sign),
      .shift(in_shift[l*SHIFT_W +: SHIFT_W]),
      .term (term[l])
    );
  end

  assign in_ready  = (state == ST_ACC) && !clear;
  assign accept    = in_valid && in_ready;
  assign buf_free  = !out_valid || out_ready;
  assign dbg_state = (state == ST_REDUCE);
  assign eff_m     = ({1'b0, mode_q} > MAX_M) ? MAX_M[1:0] : mode_q;

  // Lane j belongs to group j >> m; groups past NUM_BCE >> m stay zero.
  always_comb begin
    for (int g = 0; g < NUM_BCE; g++) begin
      grp[g] = '0;
      for (int j = 0; j < NUM_BCE; j++) begin
        if ((j >> eff_m) == g) grp[g] = grp[g] + acc[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_ACC;
      cnt       <= '0;
      mode_q    <= MODE_G1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      for (int l = 0; l < NUM_BCE; l++) acc[l] <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_ACC: begin
          if (clear) begin
            cnt <= '0;
            for (int l = 0; l < NUM_BCE; l++) acc[l] <= '0;
          end else if (accept) begin
            for (int l = 0; l < NUM_BCE; l++) acc[l] <= acc[l] + term[l];
            if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
            if (in_last) begin
              mode_q <= in_mode;
              state  <= ST_REDUCE;
            end
          end
        end
        ST_REDUCE: begin
          // Loading wins over the concurrent handshake, keeping out_valid high.
          if (buf_free) begin
            for (int g = 0; g < NUM_BCE; g++) out_data[g*ACC_W +: ACC_W] <= grp[g];
            out_count <= cnt;
            out_valid <= 1'b1;
            cnt       <= '0;
            for (int l = 0; l < NUM_BCE; l++) acc[l] <= '0;
            state <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_param.sv
// Directed bench for pe_param: stimulus pushes hand-computed results into a
// queue, and a monitor pops and compares on every output handshake.
module tb_pe_param;
  import pe_param_pkg::*;

  localparam int NB   = 4;
  localparam int AP   = 8;
  localparam int AW   = 8;
  localparam int SW   = 3;
  localparam int ACCW = 24;
  localparam int CW   = 8;
  localparam int DW   = NB * ACCW;
  localparam int EW   = CW + DW;

  logic                 clk;
  logic                 rst;
  logic [NB*AP*AW-1:0]  in_act;
  logic [NB*AP-1:0]     in_wcol;
  logic                 in_sign;
  logic [NB*SW-1:0]     in_shift;
  logic                 in_last;
  logic [1:0]           in_mode;
  logic                 in_valid;
  logic                 in_ready;
  logic                 clear;
  logic [DW-1:0]        out_data;
  logic [CW-1:0]        out_count;
  logic                 out_valid;
  logic                 out_ready;
  logic                 dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];

  pe_param #(
    .NUM_BCE(NB), .ACT_PER_BCE(AP), .ACT_W(AW), .SHIFT_W(SW), .ACC_W(ACCW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_act(in_act), .in_wcol(in_wcol), .in_sign(in_sign),
    .in_shift(in_shift), .in_last(in_last), .in_mode(in_mode), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [EW-1:0] pack(input int s0, input int s1, input int s2,
                                         input int s3, input int cnt);
    return {CW'(cnt), ACCW'(s3), ACCW'(s2), ACCW'(s1), ACCW'(s0)};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One beat with every activation = a, every lane column = w, every shift = sh.
  task automatic beat(input logic [AW-1:0] a, input logic [AP-1:0] w, input logic sg,
                      input logic [SW-1:0] sh, input logic last, input logic [1:0] md);
    int guard;
    @(negedge clk);
    in_act   = {NB*AP{a}};
    in_wcol  = {NB{w}};
    in_sign  = sg;
    in_shift = {NB{sh}};
    in_last  = last;
    in_mode  = md;
    in_valid = 1'b1;
    guard    = 0;
    #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL beat_accept_timeout: in_ready %0b, expected 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic set_out_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("drain_queue_empty", 128'(exp_q.size()), 128'd0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin : monitor
    logic [EW-1:0] e;
    if (rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h, expected none", {out_count, out_data});
      end else begin
        e = exp_q.pop_front();
        check("result", 128'({out_count, out_data}), 128'(e));
      end
    end
  end

  initial begin : stim
    int t0;
    rst = 1'b0; in_act = '0; in_wcol = '0; in_sign = 1'b0; in_shift = '0;
    in_last = 1'b0; in_mode = 2'd0; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    #1;
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_out_data", 128'(out_data), 128'd0);
    check("reset_out_count", 128'(out_count), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 128'(in_ready), 128'd1);
    check("state_after_reset", 128'(dbg_state), 128'(ST_ACC));

    // Two beats of 96 per lane, mode 0; check the REDUCE cycle timing.
    exp_q.push_back(pack(192, 192, 192, 192, 2));
    beat(3, 8'hFF, 0, 2, 0, 0);
    beat(3, 8'hFF, 0, 2, 1, 0);
    @(negedge clk);
    check("reduce_in_ready_low", 128'(in_ready), 128'd0);
    check("reduce_out_valid_low", 128'(out_valid), 128'd0);
    @(negedge clk);
    check("out_valid_edge_after_last", 128'(out_valid), 128'd1);

    // Group modes 2, 1, 3 (3 behaves as 2 with four lanes).
    exp_q.push_back(pack(768, 0, 0, 0, 2));
    beat(3, 8'hFF, 0, 2, 0, 0);
    beat(3, 8'hFF, 0, 2, 1, 2);
    exp_q.push_back(pack(384, 384, 0, 0, 2));
    beat(3, 8'hFF, 0, 2, 0, 0);
    beat(3, 8'hFF, 0, 2, 1, 1);
    exp_q.push_back(pack(768, 0, 0, 0, 2));
    beat(3, 8'hFF, 0, 2, 0, 0);
    beat(3, 8'hFF, 0, 2, 1, 3);

    // Signed terms: 96 - 24 = 72; three negated 96s = -288.
    exp_q.push_back(pack(72, 72, 72, 72, 2));
    beat(3, 8'hFF, 0, 2, 0, 0);
    beat(3, 8'hFF, 1, 0, 1, 0);
    exp_q.push_back(pack(-288, -288, -288, -288, 3));
    beat(3, 8'hFF, 1, 2, 0, 0);
    beat(3, 8'hFF, 1, 2, 0, 0);
    beat(3, 8'hFF, 1, 2, 1, 0);

    // Back-to-back single-beat passes: one accepted beat every 2 cycles.
    repeat (3) exp_q.push_back(pack(24, 24, 24, 24, 1));
    beat(3, 8'hFF, 0, 0, 1, 0);
    t0 = cyc;
    beat(3, 8'hFF, 0, 0, 1, 0);
    beat(3, 8'hFF, 0, 0, 1, 0);
    check("back_to_back_cycles", 128'(cyc - t0), 128'd4);
    drain();

    // Blocked buffer: pass B waits in REDUCE until result A is consumed.
    set_out_ready(1'b0);
    exp_q.push_back(pack(192, 192, 192, 192, 2));
    exp_q.push_back(pack(8, 8, 8, 8, 1));
    beat(3, 8'hFF, 0, 2, 0, 0);
    beat(3, 8'hFF, 0, 2, 1, 0);
    beat(1, 8'hFF, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("blocked_hold", 128'({in_ready, out_valid, dbg_state}), 128'(3'b011));
    end
    set_out_ready(1'b1);
    @(negedge clk);
    @(negedge clk);
    check("load_on_handshake_valid", 128'({out_valid, dbg_state}), 128'(2'b10));
    drain();

    // Clear after three beats drops the partial pass and the concurrent beat.
    beat(3, 8'hFF, 0, 2, 0, 0);
    beat(3, 8'hFF, 0, 2, 0, 0);
    beat(3, 8'hFF, 0, 2, 0, 0);
    @(negedge clk);
    in_act = {NB*AP{8'd3}}; in_wcol = '1; in_last = 1'b1; in_valid = 1'b1; clear = 1'b1;
    #1;
    check("clear_in_ready_low", 128'(in_ready), 128'd0);
    @(posedge clk);
    #1 clear = 1'b0;
    in_valid = 1'b0;
    exp_q.push_back(pack(32, 32, 32, 32, 1));
    beat(2, 8'hFF, 0, 1, 1, 0);
    drain();

    // 300 beats saturate the 8-bit beat counter; sums still wrap-free.
    exp_q.push_back(pack(1200, 0, 0, 0, 255));
    for (int i = 0; i < 299; i++) beat(1, 8'h01, 0, 0, 0, 2);
    beat(1, 8'h01, 0, 0, 1, 2);
    drain();

    // Asynchronous reset with a result held and a partial pass in flight.
    set_out_ready(1'b0);
    beat(5, 8'hFF, 0, 0, 1, 0);
    beat(5, 8'hFF, 0, 0, 0, 0);
    @(negedge clk);
    check("held_before_reset", 128'(out_valid), 128'd1);
    #2 rst = 1'b0;
    #1;
    check("async_reset_out_valid", 128'(out_valid), 128'd0);
    check("async_reset_out_data", 128'(out_data), 128'd0);
    check("async_reset_out_count", 128'(out_count), 128'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_after_release", 128'({in_ready, out_valid}), 128'(2'b10));
    exp_q.push_back(pack(8, 8, 8, 8, 1));
    beat(1, 8'hFF, 0, 0, 1, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
